// File: rtl/adat_tx.sv
// adat_tx: ADAT optical transmitter; one handshaked frame of up to 8 samples is sent
// per 256-bit NRZI frame, with a holding register so the next frame can be queued.
module adat_tx #(
   parameter int CHANNELS     = 8,
   parameter int SAMPLE_WIDTH = 24,
   parameter int CLK_DIV      = 2
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             en_i,
   input  logic [CHANNELS*SAMPLE_WIDTH-1:0] samples_i,
   input  logic [3:0]                       user_i,
   input  logic                             valid_i,
   output logic                             ready_o,
   output logic                             adat_o,
   output logic                             frame_start_o,
   output logic                             underrun_o
);
   localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   typedef enum logic {IDLE, SEND} state_t;
   state_t state, state_nx;
   logic [CHANNELS*SAMPLE_WIDTH-1:0] hold_data, src;
   logic [3:0] hold_user;
   logic hold_full, bit_end, last, load, xfer;
   logic [DW-1:0] div;
   logic [7:0] bit_cnt;
   logic [7:0][23:0] slots;
   logic [255:0] sh, fr;

   assign ready_o = !hold_full;
   assign xfer = valid_i && !hold_full;
   assign bit_end = div == DW'(CLK_DIV - 1);
   assign last = state == SEND && bit_end && bit_cnt == 8'd255;
   assign src = hold_full ? hold_data : '0;

   // Samples are left-justified into 24-bit slots; unused channels send zero.
   for (genvar c = 0; c < 8; c++) begin : g_slot
      if (c < CHANNELS) begin : g_on
         assign slots[c] = 24'(src[c*SAMPLE_WIDTH +: SAMPLE_WIDTH]) << (24 - SAMPLE_WIDTH);
      end else begin : g_off
         assign slots[c] = '0;
      end
   end

   always_comb begin
      fr = '0;
      fr[10] = 1'b1;
      fr[15] = 1'b1;
      for (int i = 0; i < 4; i++) fr[11+i] = hold_full ? hold_user[3-i] : 1'b0;
      for (int c = 0; c < 8; c++)
         for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 4; i++) fr[16+30*c+5*n+i] = slots[c][23-4*n-i];
            fr[20+30*c+5*n] = 1'b1;
         end
   end

   always_comb begin
      load = en_i && (state == IDLE || last);
      state_nx = load ? SEND : last ? IDLE : state;
   end

   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) state <= IDLE;
      else state <= state_nx;

   // Frame bits sit at sh[0]; each bit-period start shifts and NRZI-applies the next bit.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hold_full <= 1'b0;
         hold_data <= '0;
         hold_user <= '0;
         sh <= '0;
         div <= '0;
         bit_cnt <= '0;
         adat_o <= 1'b0;
         frame_start_o <= 1'b0;
         underrun_o <= 1'b0;
      end else begin
         frame_start_o <= load;
         underrun_o <= load && !hold_full;
         if (xfer) begin
            hold_full <= 1'b1;
            hold_data <= samples_i;
            hold_user <= user_i;
         end else if (load) hold_full <= 1'b0;
         if (load) begin
            sh <= fr;
            adat_o <= adat_o ^ fr[0];
            div <= '0;
            bit_cnt <= '0;
         end else if (state == SEND) begin
            div <= bit_end ? '0 : div + 1'b1;
            if (bit_end) begin
               bit_cnt <= bit_cnt + 8'd1;
               sh <= sh >> 1;
               adat_o <= adat_o ^ sh[1];
            end
         end
      end
   end
endmodule
